// File: rtl/mpte_memory_stage.sv
// mpte_memory_stage
//   MPT walker stage sitting between two MPTE parsing stages. A walking
//   transaction carries the physical address of the next MPTE in its mpte
//   field; this stage issues a single read for that address and replaces
//   mpte with the returned entry. Skipped, invalid or already completed
//   transactions bypass memory unchanged. The result is held in a register
//   towards the next parsing stage.
//
//   Transaction layout (mptw_transaction_t, LSB first):
//     [0]      valid
//     [2:1]    walking        (2'b11 = MPT_WALKING_SKIP)
//     [3]      completed
//     [4]      access_error
//     [5]      format_error
//     [6]      plb_hit
//     [8:7]    access_type
//     [12:9]   id
//     [13]     mmpt
//     [15:14]  spa
//     [W-1:16] mpte
//
//   Ports:
//     clk_i, rst_ni                    clock, async active-low reset
//     stage_slave_*                    valid/ready/data from upstream parser
//     stage_master_*                   valid/ready/data to downstream parser
//     mem_req_o/mem_gnt_i/mem_addr_o   read request channel
//     mem_rvalid_i/mem_rdata_i/mem_err_i  read response channel
//     busy_o                           stage is not idle
module mpte_memory_stage #(
    parameter int unsigned PIPELINE_SLAVE_DATA_WIDTH  = 32,
    parameter int unsigned PIPELINE_MASTER_DATA_WIDTH = 32,
    parameter int unsigned WALKING_LEVEL              = 0,
    parameter int unsigned MEM_ADDR_WIDTH             = 32,
    parameter int unsigned MEM_DATA_WIDTH             = 64,
    parameter int unsigned TIMEOUT_CYCLES             = 256
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  stage_slave_valid,
    output logic                                  stage_slave_ready,
    input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  stage_slave_data,
    output logic                                  stage_master_valid,
    input  logic                                  stage_master_ready,
    output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] stage_master_data,
    output logic                                  mem_req_o,
    input  logic                                  mem_gnt_i,
    output logic [MEM_ADDR_WIDTH-1:0]             mem_addr_o,
    input  logic                                  mem_rvalid_i,
    input  logic [MEM_DATA_WIDTH-1:0]             mem_rdata_i,
    input  logic                                  mem_err_i,
    output logic                                  busy_o
);

    localparam int unsigned SW          = PIPELINE_SLAVE_DATA_WIDTH;
    localparam int unsigned F_VALID     = 0;
    localparam int unsigned F_WALK      = 1;
    localparam int unsigned F_COMPLETED = 3;
    localparam int unsigned F_ACC_ERR   = 4;
    localparam int unsigned F_MPTE      = 16;
    localparam int unsigned MPTE_W      = SW - F_MPTE;
    localparam int unsigned CNT_W       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] MPT_WALKING_SKIP = 2'b11;

    // Elaboration-time parameter sanity checks.
    if (PIPELINE_MASTER_DATA_WIDTH != PIPELINE_SLAVE_DATA_WIDTH) begin : g_chk_width
        $error("master and slave transaction widths differ");
    end
    if (SW < F_MPTE + 3) begin : g_chk_layout
        $error("transaction too narrow to hold an mpte field");
    end
    if (MEM_DATA_WIDTH < MPTE_W) begin : g_chk_data
        $error("memory data narrower than the mpte field");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end
    if (WALKING_LEVEL > 7) begin : g_chk_level
        $error("WALKING_LEVEL out of range for the walker");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, OUT} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    txn_q, txn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic is_bypass(input logic [SW-1:0] t);
        return !t[F_VALID] || (t[F_WALK +: 2] == MPT_WALKING_SKIP) || t[F_COMPLETED];
    endfunction

    function automatic logic [SW-1:0] fault(input logic [SW-1:0] t, input logic clear_mpte);
        logic [SW-1:0] r;
        r                = t;
        r[F_ACC_ERR]     = 1'b1;
        r[F_COMPLETED]   = 1'b1;
        r[F_WALK +: 2]   = MPT_WALKING_SKIP;
        if (clear_mpte) begin
            r[SW-1:F_MPTE] = '0;
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] respond(input logic [SW-1:0] t, input logic err,
                                              input logic [MEM_DATA_WIDTH-1:0] rdata);
        logic [SW-1:0] r;
        if (err) begin
            r = fault(t, 1'b1);
        end else begin
            r              = t;
            r[SW-1:F_MPTE] = MPTE_W'(rdata);
        end
        return r;
    endfunction

    always_comb begin
        state_d           = state_q;
        txn_d             = txn_q;
        cnt_d             = cnt_q;
        stage_slave_ready = 1'b0;
        case (state_q)
            IDLE: begin
                stage_slave_ready = 1'b1;
                if (stage_slave_valid) begin
                    if (is_bypass(stage_slave_data)) begin
                        txn_d   = stage_slave_data;
                        state_d = OUT;
                    end else if (stage_slave_data[F_MPTE +: 3] != 3'b000) begin
                        txn_d   = fault(stage_slave_data, 1'b0);
                        state_d = OUT;
                    end else begin
                        txn_d   = stage_slave_data;
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // A response in the grant cycle beats the timeout; a bare grant
                // on the last counted cycle still times out.
                if (mem_gnt_i && mem_rvalid_i) begin
                    txn_d   = respond(txn_q, mem_err_i, mem_rdata_i);
                    state_d = OUT;
                end else if (cnt_q == CNT_LAST) begin
                    txn_d   = fault(txn_q, 1'b1);
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (mem_gnt_i) begin
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rvalid_i) begin
                    txn_d   = respond(txn_q, mem_err_i, mem_rdata_i);
                    state_d = OUT;
                end else if (cnt_q == CNT_LAST) begin
                    txn_d   = fault(txn_q, 1'b1);
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OUT: begin
                // Only a bypass transaction may be taken while draining, since
                // it can overwrite the output register directly.
                stage_slave_ready = stage_master_ready && is_bypass(stage_slave_data);
                if (stage_master_ready) begin
                    if (stage_slave_valid && stage_slave_ready) begin
                        txn_d = stage_slave_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            txn_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stage_master_valid = (state_q == OUT);
    assign stage_master_data  = PIPELINE_MASTER_DATA_WIDTH'(txn_q);
    assign mem_req_o          = (state_q == REQ);
    assign mem_addr_o         = (state_q == REQ) ? MEM_ADDR_WIDTH'(txn_q[SW-1:F_MPTE]) : '0;
    assign busy_o             = (state_q != IDLE);

endmodule

// File: tb/tb_mpte_memory_stage.sv
// Self-checking bench for mpte_memory_stage: a driver issues transactions and
// pushes expected outputs computed by a reference model; a responder plays a
// memory following a per-transaction plan; a monitor pops and compares.
module tb_mpte_memory_stage;

    localparam int unsigned SW = 80;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned T  = 16;

    typedef struct {
        int unsigned   g;      // cycles after REQ entry until grant
        int unsigned   d;      // cycles from grant to rvalid (0 = same cycle)
        logic [DW-1:0] rdata;
        logic          err;
        logic [AW-1:0] addr;
    } plan_t;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          slave_valid = 1'b0;
    logic          slave_ready;
    logic [SW-1:0] slave_data = '0;
    logic          master_valid;
    logic          master_ready = 1'b0;
    logic [SW-1:0] master_data;
    logic          mem_req;
    logic          gnt = 1'b0;
    logic [AW-1:0] addr;
    logic          rvalid = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          err = 1'b0;
    logic          busy;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    int unsigned   req_cycles = 0;
    int unsigned   ready_block = 0;
    bit            resp_busy = 1'b0;
    bit            in_reset_test = 1'b0;
    plan_t         plan_q[$];
    logic [SW-1:0] sb_q[$];

    mpte_memory_stage #(
        .PIPELINE_SLAVE_DATA_WIDTH (SW),
        .PIPELINE_MASTER_DATA_WIDTH(SW),
        .WALKING_LEVEL             (1),
        .MEM_ADDR_WIDTH            (AW),
        .MEM_DATA_WIDTH            (DW),
        .TIMEOUT_CYCLES            (T)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .stage_slave_valid (slave_valid),
        .stage_slave_ready (slave_ready),
        .stage_slave_data  (slave_data),
        .stage_master_valid(master_valid),
        .stage_master_ready(master_ready),
        .stage_master_data (master_data),
        .mem_req_o         (mem_req),
        .mem_gnt_i         (gnt),
        .mem_addr_o        (addr),
        .mem_rvalid_i      (rvalid),
        .mem_rdata_i       (rdata),
        .mem_err_i         (err),
        .busy_o            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_bypass(input logic [SW-1:0] t);
        return (t[0] == 1'b0) || (t[2:1] == 2'b11) || (t[3] == 1'b1);
    endfunction

    function automatic bit needs_mem(input logic [SW-1:0] t);
        return !is_bypass(t) && (t[18:16] == 3'b000);
    endfunction

    function automatic logic [SW-1:0] model(input logic [SW-1:0] t, input plan_t p);
        logic [SW-1:0] e;
        e = t;
        if (is_bypass(t)) return t;
        if (t[18:16] != 3'b000 || p.err || (p.g + p.d >= T)) begin
            e[4]   = 1'b1;
            e[3]   = 1'b1;
            e[2:1] = 2'b11;
            if (t[18:16] == 3'b000) e[SW-1:16] = '0;
            return e;
        end
        e[SW-1:16] = p.rdata;
        return e;
    endfunction

    function automatic int unsigned exp_lat(input logic [SW-1:0] t, input plan_t p);
        if (!needs_mem(t)) return 1;
        return 2 + ((p.g + p.d < T) ? (p.g + p.d) : (T - 1));
    endfunction

    function automatic int unsigned exp_req(input logic [SW-1:0] t, input plan_t p);
        if (!needs_mem(t)) return 0;
        return (p.g < T) ? (p.g + 1) : T;
    endfunction

    function automatic logic [SW-1:0] mk_txn(input logic v, input logic [1:0] walk,
                                             input logic comp, input logic [63:0] mpte);
        logic [SW-1:0] t;
        t          = '0;
        t[0]       = v;
        t[2:1]     = walk;
        t[3]       = comp;
        t[15:4]    = 12'($urandom);
        t[SW-1:16] = mpte;
        return t;
    endfunction

    function automatic plan_t mk_plan(input int unsigned g, input int unsigned d,
                                      input logic [DW-1:0] rd, input logic e, input logic [SW-1:0] t);
        plan_t p;
        p.g     = g;
        p.d     = d;
        p.rdata = rd;
        p.err   = e;
        p.addr  = t[16 +: AW];
        return p;
    endfunction

    // ---------------- memory responder ----------------
    task automatic run_plan(input plan_t p);
        int unsigned c;
        bit granted, done;
        c = 0; granted = 0; done = 0;
        while (!done) begin
            if (!in_reset_test) begin
                if (!granted && c < T) begin
                    chk(mem_req == 1'b1, "req_hold", SW'(mem_req), SW'(1));
                    chk(addr == p.addr, "addr_hold", SW'(addr), SW'(p.addr));
                end else if (!granted) begin
                    chk(mem_req == 1'b0, "req_drop", SW'(mem_req), SW'(0));
                    done = 1;
                end else if (c > p.g) begin
                    chk(mem_req == 1'b0, "req_after_gnt", SW'(mem_req), SW'(0));
                end
                if (c < T) chk(slave_ready == 1'b0, "slave_ready_busy", SW'(slave_ready), SW'(0));
            end else if (!granted && c >= T) begin
                done = 1;
            end
            if (!done) begin
                if (!granted && c == p.g) begin
                    gnt = 1'b1;
                    granted = 1;
                end
                if (granted && c == p.g + p.d) begin
                    rvalid = 1'b1;
                    rdata  = p.rdata;
                    err    = p.err;
                    done   = 1;
                end
                @(negedge clk); #1;
                gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = {$urandom, $urandom};
                c++;
                if (c > 80) done = 1;
            end
        end
        resp_busy = 1'b0;
    endtask

    initial begin : responder
        forever begin
            @(negedge clk); #1;
            if (plan_q.size() != 0 && mem_req) run_plan(plan_q.pop_front());
        end
    end

    initial begin : req_counter
        forever begin
            @(negedge clk); #1;
            if (mem_req) req_cycles++;
        end
    end

    // ---------------- output monitor ----------------
    initial begin : monitor
        bit pending;
        logic [SW-1:0] held, e;
        pending = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (ready_block > 0) begin
                master_ready = 1'b0;
                ready_block--;
            end else begin
                master_ready = ($urandom_range(0, 3) != 0);
            end
            #1;
            if (!rst_ni) begin
                pending = 0;
            end else begin
                if (pending) chk(master_valid && master_data == held, "out_hold", master_data, held);
                pending = 0;
                if (master_valid && master_ready) begin
                    if (sb_q.size() == 0) begin
                        chk(1'b0, "unexpected_out", master_data, '0);
                    end else begin
                        e = sb_q.pop_front();
                        chk(master_data == e, "out_data", master_data, e);
                    end
                end else if (master_valid) begin
                    pending = 1;
                    held = master_data;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [SW-1:0] t, input plan_t p, input bit stall_out);
        int unsigned lat, guard, r0, el;
        bit seen;
        el = exp_lat(t, p);
        r0 = req_cycles;
        if (needs_mem(t)) begin
            plan_q.push_back(p);
            resp_busy = 1'b1;
        end
        sb_q.push_back(model(t, p));
        @(negedge clk);
        slave_valid = 1'b1;
        slave_data  = t;
        #1;
        if (stall_out) ready_block = el + 3;
        chk(slave_ready == 1'b1, "in_ready", SW'(slave_ready), SW'(1));
        lat = 0; seen = 0;
        while (!seen && lat < 60) begin
            @(negedge clk);
            slave_valid = 1'b0;
            #1;
            lat++;
            if (master_valid) seen = 1;
        end
        chk(seen && lat == el, "latency", SW'(lat), SW'(el));
        guard = 0;
        while ((sb_q.size() != 0 || resp_busy || master_valid) && guard < 300) begin
            @(negedge clk); #1;
            guard++;
        end
        chk(guard < 300, "drain", SW'(guard), SW'(300));
        chk(req_cycles - r0 == exp_req(t, p), "req_cycles", SW'(req_cycles - r0), SW'(exp_req(t, p)));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin : driver
        logic [SW-1:0] t;
        plan_t p0;
        int unsigned guard, r0;
        bit stray;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk({master_valid, mem_req, busy} == 3'b000, "reset_ctrl", SW'({master_valid, mem_req, busy}), '0);
        chk(master_data == '0, "reset_data", master_data, '0);
        chk(addr == '0, "reset_addr", SW'(addr), '0);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk(slave_ready == 1'b1, "ready_after_reset", SW'(slave_ready), SW'(1));

        // skip pass-through
        t = mk_txn(1'b1, 2'b11, 1'b0, 64'h1234);
        issue(t, mk_plan(0, 0, '0, 1'b0, t), 1'b0);
        // normal read: grant with request, rvalid one cycle later
        t = mk_txn(1'b1, 2'b01, 1'b0, 64'h8000_0040);
        issue(t, mk_plan(0, 1, 64'h0000_0000_0ABC_0001, 1'b0, t), 1'b0);
        // grant stall of 5 cycles plus 4 cycles of output backpressure
        t = mk_txn(1'b1, 2'b00, 1'b0, 64'h0000_0001_2345_6780);
        issue(t, mk_plan(5, 1, {$urandom, $urandom}, 1'b0, t), 1'b1);
        // bus error
        t = mk_txn(1'b1, 2'b10, 1'b0, 64'h0000_0000_0000_1000);
        issue(t, mk_plan(1, 2, {$urandom, $urandom}, 1'b1, t), 1'b0);
        // timeout with a stale rvalid at cycle 20
        t = mk_txn(1'b1, 2'b01, 1'b0, 64'h0000_0000_0000_2000);
        issue(t, mk_plan(0, 20, {$urandom, $urandom}, 1'b0, t), 1'b0);
        // misaligned address
        t = mk_txn(1'b1, 2'b01, 1'b0, 64'h1004);
        issue(t, mk_plan(0, 0, '0, 1'b0, t), 1'b0);
        // timeout boundaries: last accepted cycle, first timed-out cycle, no grant at all
        t = mk_txn(1'b1, 2'b01, 1'b0, 64'h0000_0000_0000_3000);
        issue(t, mk_plan(0, T - 1, {$urandom, $urandom}, 1'b0, t), 1'b0);
        t = mk_txn(1'b1, 2'b01, 1'b0, 64'h0000_0000_0000_3008);
        issue(t, mk_plan(0, T, {$urandom, $urandom}, 1'b0, t), 1'b0);
        t = mk_txn(1'b1, 2'b01, 1'b0, 64'h0000_0000_0000_3010);
        issue(t, mk_plan(T - 1, 0, {$urandom, $urandom}, 1'b0, t), 1'b0);
        t = mk_txn(1'b1, 2'b01, 1'b0, 64'h0000_0000_0000_3018);
        issue(t, mk_plan(T, 0, {$urandom, $urandom}, 1'b0, t), 1'b0);

        // back-to-back bypass burst
        r0 = req_cycles;
        for (int i = 0; i < 8; i++) begin
            t = mk_txn(1'b1, 2'b11, 1'($urandom_range(0, 1)), {$urandom, $urandom});
            @(negedge clk);
            slave_valid = 1'b1;
            slave_data  = t;
            #1;
            guard = 0;
            while (!slave_ready && guard < 50) begin
                @(negedge clk); #1;
                guard++;
            end
            chk(guard < 50, "burst_accept", SW'(guard), SW'(50));
            sb_q.push_back(t);
        end
        @(negedge clk);
        slave_valid = 1'b0;
        guard = 0;
        while ((sb_q.size() != 0 || master_valid) && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        chk(guard < 200, "burst_drain", SW'(guard), SW'(200));
        chk(req_cycles == r0, "burst_no_req", SW'(req_cycles - r0), '0);

        // reset in WAIT_RSP, then a stale rvalid
        in_reset_test = 1'b1;
        t = mk_txn(1'b1, 2'b01, 1'b0, 64'h0000_0000_0000_4000);
        p0 = mk_plan(0, 12, {$urandom, $urandom}, 1'b0, t);
        plan_q.push_back(p0);
        resp_busy = 1'b1;
        @(negedge clk);
        slave_valid = 1'b1;
        slave_data  = t;
        @(negedge clk);
        slave_valid = 1'b0;
        @(negedge clk); #1;
        chk(busy && !mem_req, "in_wait_rsp", SW'({busy, mem_req}), SW'(2'b10));
        rst_ni = 1'b0;
        #1;
        chk({master_valid, mem_req, busy} == 3'b000, "midwalk_reset_ctrl", SW'({master_valid, mem_req, busy}), '0);
        chk(master_data == '0 && addr == '0, "midwalk_reset_data", master_data, '0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk(slave_ready == 1'b1 && busy == 1'b0, "ready_after_midwalk", SW'({slave_ready, busy}), SW'(2'b10));
        stray = 0;
        guard = 0;
        while ((resp_busy || guard < 3) && guard < 100) begin
            @(negedge clk); #1;
            if (master_valid || busy) stray = 1;
            guard++;
        end
        chk(!stray && !resp_busy, "stale_rsp_ignored", SW'({stray, resp_busy}), '0);
        in_reset_test = 1'b0;

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            int unsigned k, g, d;
            logic [63:0] m;
            logic [1:0] w;
            k = $urandom_range(0, 9);
            m = {$urandom, $urandom};
            w = 2'($urandom_range(0, 2));
            case (k)
                0: t = mk_txn(1'b1, 2'b11, 1'($urandom_range(0, 1)), m);
                1: t = mk_txn(1'b0, w, 1'b0, m);
                2: t = mk_txn(1'b1, w, 1'b1, m);
                3: begin
                    if (m[2:0] == 3'b000) m[0] = 1'b1;
                    t = mk_txn(1'b1, w, 1'b0, m);
                end
                default: begin
                    m[2:0] = 3'b000;
                    t = mk_txn(1'b1, w, 1'b0, m);
                end
            endcase
            g = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 18) : $urandom_range(0, 3);
            d = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
            issue(t, mk_plan(g, d, {$urandom, $urandom}, 1'($urandom_range(0, 5) == 0), t),
                  1'($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
